// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
// Debug trace stage that sits behind the single-cycle core. It keeps a
// circular pre-trigger history of the core's per-cycle observation word and a
// fixed post-trigger window. Once capture completes, it replays the retained
// window oldest-first over a valid/ready handshake.
module trace_capture_buffer #(
   parameter int DEPTH = 16,
   parameter int POST  = 8,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic [12:0] trig_mask,
   input  logic [12:0] trig_match,
   input  logic [12:0] z_MD,
   input  logic [31:0] z_ALU_out,
   input  logic [31:0] z_RF_WD,
   input  logic        rd_ready,
   output logic        rd_valid,
   output logic [76:0] rd_data,
   output logic [1:0]  st,
   output logic        triggered
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // The fill count needs one bit more than a pointer so that it can hold DEPTH.
   localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] POST_INIT = AW'(POST);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

   state_t         st_q, st_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    fill_q, fill_d;
   logic [AW:0]    rd_cnt_q, rd_cnt_d;
   logic [AW-1:0]  post_cnt_q, post_cnt_d;
   logic           triggered_q, triggered_d;
   logic           rd_valid_q, rd_valid_d;

   logic [76:0]    mem_q [DEPTH];

   logic           hit_s;
   logic           wr_en_s;
   logic           rd_fire_s;
   logic [76:0]    sample_s;
   logic [AW-1:0]  wr_ptr_inc_s;
   logic [AW:0]    fill_inc_s;
   logic [76:0]    rd_data_s;

   assign hit_s        = ((z_MD & trig_mask) == trig_match);
   assign sample_s     = {z_MD, z_ALU_out, z_RF_WD};
   assign wr_en_s      = (st_q == ST_ARMED) || (st_q == ST_POST);
   assign wr_ptr_inc_s = wr_ptr_q + PTR_ONE;
   assign fill_inc_s   = (fill_q == FILL_MAX) ? fill_q : (fill_q + CNT_ONE);
   // A readout handshake that coincides with arm is dropped: the restart wins.
   assign rd_fire_s    = rd_valid_q && rd_ready && !arm;

   // Next-state logic for the capture/readout controller and its counters.
   always_comb begin
      st_d        = st_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      rd_cnt_d    = rd_cnt_q;
      post_cnt_d  = post_cnt_q;
      triggered_d = triggered_q;
      case (st_q)
         ST_IDLE: begin
            if (arm) begin
               st_d        = ST_ARMED;
               wr_ptr_d    = {AW{1'b0}};
               fill_d      = {(AW+1){1'b0}};
               triggered_d = 1'b0;
            end else begin
               st_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            wr_ptr_d = wr_ptr_inc_s;
            fill_d   = fill_inc_s;
            if (hit_s) begin
               triggered_d = 1'b1;
               post_cnt_d  = POST_INIT;
               if (POST_INIT != {AW{1'b0}}) begin
                  st_d = ST_POST;
               end else begin
                  // No post window: the trigger sample closes the capture.
                  st_d     = ST_DONE;
                  rd_cnt_d = fill_inc_s;
                  rd_ptr_d = wr_ptr_inc_s - fill_inc_s[AW-1:0];
               end
            end else begin
               st_d = ST_ARMED;
            end
         end
         ST_POST: begin
            wr_ptr_d   = wr_ptr_inc_s;
            fill_d     = fill_inc_s;
            post_cnt_d = post_cnt_q - PTR_ONE;
            if (post_cnt_q == PTR_ONE) begin
               // Oldest retained entry sits fill entries behind the write pointer;
               // a saturated fill wraps this back to the write pointer itself.
               st_d     = ST_DONE;
               rd_cnt_d = fill_inc_s;
               rd_ptr_d = wr_ptr_inc_s - fill_inc_s[AW-1:0];
            end else begin
               st_d = ST_POST;
            end
         end
         ST_DONE: begin
            if (arm) begin
               st_d        = ST_ARMED;
               wr_ptr_d    = {AW{1'b0}};
               fill_d      = {(AW+1){1'b0}};
               triggered_d = 1'b0;
            end else if (rd_fire_s) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               rd_cnt_d = rd_cnt_q - CNT_ONE;
               if (rd_cnt_q == CNT_ONE) begin
                  st_d = ST_IDLE;
               end else begin
                  st_d = ST_DONE;
               end
            end else if (rd_cnt_q == {(AW+1){1'b0}}) begin
               st_d = ST_IDLE;
            end else begin
               st_d = ST_DONE;
            end
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
      rd_valid_d = (st_d == ST_DONE) && (rd_cnt_d != {(AW+1){1'b0}});
   end

   // Controller state, pointers, counters and the registered valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q        <= ST_IDLE;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         fill_q      <= {(AW+1){1'b0}};
         rd_cnt_q    <= {(AW+1){1'b0}};
         post_cnt_q  <= {AW{1'b0}};
         triggered_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         rd_cnt_q    <= rd_cnt_d;
         post_cnt_q  <= post_cnt_d;
         triggered_q <= triggered_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // Trace storage: one sample per cycle while capturing; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= sample_s;
      end
   end

   // Read port is combinational and forced to zero outside of readout.
   always_comb begin
      rd_data_s = 77'd0;
      if (st_q == ST_DONE) begin
         rd_data_s = mem_q[rd_ptr_q];
      end else begin
         rd_data_s = 77'd0;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_s;
   assign st        = st_q;
   assign triggered = triggered_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Testbench for trace_capture_buffer: directed capture scenarios with a
// queue-based scoreboard and independent readout monitors.
module tb_trace_capture_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        arm, arm1;
   logic [12:0] trig_mask, trig_match, z_md;
   logic [31:0] z_alu, z_wd;
   logic        rd_ready, rd_ready1;
   logic        rd_valid, rd_valid1;
   logic [76:0] rd_data, rd_data1;
   logic [1:0]  st, st1;
   logic        triggered, triggered1;

   int total = 0;
   int bad   = 0;

   logic [76:0] cap_q [$];
   logic [76:0] exp_q [$];
   logic [76:0] exp1_q [$];
   logic [31:0] got_alu [$];
   int          pop_cnt  = 0;
   int          pop1_cnt = 0;

   logic        hold_v;
   logic [76:0] hold_d;
   logic [76:0] e0, e1;

   always #5 clk = ~clk;

   trace_capture_buffer #(.DEPTH(16), .POST(8), .AW(4)) dut0 (
      .clk(clk), .reset(reset), .arm(arm),
      .trig_mask(trig_mask), .trig_match(trig_match),
      .z_MD(z_md), .z_ALU_out(z_alu), .z_RF_WD(z_wd),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .st(st), .triggered(triggered)
   );

   trace_capture_buffer #(.DEPTH(16), .POST(0), .AW(4)) dut1 (
      .clk(clk), .reset(reset), .arm(arm1),
      .trig_mask(trig_mask), .trig_match(trig_match),
      .z_MD(z_md), .z_ALU_out(z_alu), .z_RF_WD(z_wd),
      .rd_ready(rd_ready1), .rd_valid(rd_valid1), .rd_data(rd_data1),
      .st(st1), .triggered(triggered1)
   );

   task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor for the POST=8 instance: scoreboard pops plus hold-stability check.
   initial begin
      hold_v = 1'b0;
      hold_d = 77'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v && rd_valid) chk("hold_stable", rd_data, hold_d);
            if (rd_valid && rd_ready && !arm) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got %0h expected none", rd_data);
               end else begin
                  e0 = exp_q.pop_front();
                  chk("rd_data", rd_data, e0);
               end
               got_alu.push_back(rd_data[63:32]);
               pop_cnt++;
            end
            hold_v = rd_valid && !rd_ready && !arm;
            hold_d = rd_data;
         end
      end
   end

   // Monitor for the POST=0 instance.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rd_valid1 && rd_ready1 && !arm1) begin
            if (exp1_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out1: got %0h expected none", rd_data1);
            end else begin
               e1 = exp1_q.pop_front();
               chk("rd_data1", rd_data1, e1);
            end
            pop1_cnt++;
         end
      end
   end

   task automatic drive(input logic [12:0] md, input logic [31:0] alu, input logic [31:0] wd);
      z_md  = md;
      z_alu = alu;
      z_wd  = wd;
      cap_q.push_back({md, alu, wd});
      @(posedge clk); #1;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   // Expected readout is the last min(samples, 16) captured samples, oldest first.
   task automatic finish_capture();
      int n;
      int s;
      n = cap_q.size();
      s = (n > 16) ? n - 16 : 0;
      for (int i = s; i < n; i++) exp_q.push_back(cap_q[i]);
      cap_q.delete();
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && st != 2'd0; i++) begin
         @(posedge clk); #1;
      end
      chk(name, 77'(st), 77'(0));
   endtask

   // 3 non-matching samples, trigger sample (ALU 0x100), 8 post samples.
   task automatic std_capture(input bit do_arm, input logic [7:0] seed);
      if (do_arm) arm_pulse();
      for (int i = 0; i < 3; i++)
         drive(13'h100 + 13'(i), {seed, 24'(i)}, {seed, 8'h5A, 16'(i)});
      drive(13'h0A1, 32'h0000_0100, {seed, 24'hFFFFFF});
      chk("trig_st", 77'(st), 77'(2));
      chk("trig_flag", 77'(triggered), 77'(1));
      for (int i = 0; i < 8; i++)
         drive(13'h110 + 13'(i), {seed, 24'(i + 16)}, {seed, 8'h5A, 16'(i + 16)});
      chk("done_st", 77'(st), 77'(3));
      finish_capture();
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; arm1 = 1'b0;
      trig_mask = 13'd0; trig_match = 13'd0;
      z_md = 13'd0; z_alu = 32'd0; z_wd = 32'd0;
      rd_ready = 1'b0; rd_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_st", 77'(st), 77'(0));
      chk("rst_valid", 77'(rd_valid), 77'(0));
      chk("rst_data", rd_data, 77'd0);
      chk("rst_trig", 77'(triggered), 77'(0));

      // Basic capture: 12 entries, trigger entry 4th.
      trig_mask = 13'h1FFF; trig_match = 13'h0A1;
      rd_ready = 1'b1; pop_cnt = 0; got_alu.delete();
      std_capture(1'b1, 8'h02);
      wait_idle("s2_idle");
      chk("s2_count", 77'(pop_cnt), 77'(12));
      chk("s2_trig_alu", 77'(got_alu[3]), 77'(32'h0000_0100));
      chk("s2_trig_kept", 77'(triggered), 77'(1));

      // Overflowed history with toggled rd_ready.
      rd_ready = 1'b0; pop_cnt = 0; got_alu.delete();
      arm_pulse();
      for (int i = 0; i < 40; i++)
         drive(13'h100 + 13'(i), 32'h0300_0000 | 32'(i), 32'h0B00_0000 | 32'(i));
      drive(13'h0A1, 32'h03AA_0100, 32'h0BAA_0000);
      for (int i = 0; i < 8; i++)
         drive(13'h140 + 13'(i), 32'h0300_0000 | 32'(i + 64), 32'h0B00_0000 | 32'(i + 64));
      chk("s3_done_st", 77'(st), 77'(3));
      finish_capture();
      for (int i = 0; i < 200 && st != 2'd0; i++) begin
         rd_ready = ((i % 3) == 0);
         @(posedge clk); #1;
      end
      rd_ready = 1'b0;
      chk("s3_idle", 77'(st), 77'(0));
      chk("s3_count", 77'(pop_cnt), 77'(16));
      chk("s3_first", 77'(got_alu[0]), 77'(32'h0300_0021));
      chk("s3_trig8", 77'(got_alu[7]), 77'(32'h03AA_0100));
      chk("s3_left", 77'(exp_q.size()), 77'(0));

      // POST=0 with an all-zero mask: trigger on the first armed sample.
      trig_mask = 13'd0; trig_match = 13'd0;
      rd_ready1 = 1'b1; pop1_cnt = 0;
      arm1 = 1'b1;
      @(posedge clk); #1;
      arm1 = 1'b0;
      drive(13'h1AB, 32'h0400_0001, 32'h0400_FFFF);
      chk("s4_done_st", 77'(st1), 77'(3));
      chk("s4_trig", 77'(triggered1), 77'(1));
      exp1_q.push_back(cap_q[0]);
      cap_q.delete();
      for (int i = 0; i < 50 && st1 != 2'd0; i++) begin
         @(posedge clk); #1;
      end
      chk("s4_idle", 77'(st1), 77'(0));
      chk("s4_count", 77'(pop1_cnt), 77'(1));
      rd_ready1 = 1'b0;

      // Abort readout with arm while 5 entries remain.
      trig_mask = 13'h1FFF; trig_match = 13'h0A1;
      rd_ready = 1'b1; pop_cnt = 0; got_alu.delete();
      std_capture(1'b1, 8'h05);
      repeat (7) @(posedge clk);
      #1;
      chk("s5_read7", 77'(pop_cnt), 77'(7));
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      chk("s5_st", 77'(st), 77'(1));
      chk("s5_valid", 77'(rd_valid), 77'(0));
      chk("s5_trig", 77'(triggered), 77'(0));
      chk("s5_left", 77'(exp_q.size()), 77'(5));
      exp_q.delete();
      pop_cnt = 0; got_alu.delete();
      std_capture(1'b0, 8'h06);
      wait_idle("s5b_idle");
      chk("s5b_count", 77'(pop_cnt), 77'(12));
      chk("s5b_trig_alu", 77'(got_alu[3]), 77'(32'h0000_0100));

      // Asynchronous reset in the middle of the post window.
      rd_ready = 1'b0;
      arm_pulse();
      drive(13'h0A1, 32'h0700_0000, 32'h0700_0001);
      drive(13'h111, 32'h0700_0002, 32'h0700_0003);
      drive(13'h112, 32'h0700_0004, 32'h0700_0005);
      chk("s6_post_st", 77'(st), 77'(2));
      #2 reset = 1'b1;
      #1;
      chk("s6_rst_st", 77'(st), 77'(0));
      chk("s6_rst_trig", 77'(triggered), 77'(0));
      chk("s6_rst_valid", 77'(rd_valid), 77'(0));
      cap_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Debug trace stage directly downstream of the single-cycle core top level; consumes the core's per-cycle observation outputs (decoder control word, ALU result, register-file write data).
- Records a circular pre-trigger history plus a fixed post-trigger window into an internal register array.
- After capture completes, plays the window back oldest-first over a valid/ready handshake to a debug consumer.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 4.
- POST, 8, samples captured after the trigger sample; legal range 0 to DEPTH-1.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle request to start a new capture.
- trig_mask  in  13  control-word bits that take part in the trigger compare.
- trig_match  in  13  required value of the masked bits.
- z_MD  in  13  core decoder control word for the current cycle.
- z_ALU_out  in  32  core ALU result for the current cycle.
- z_RF_WD  in  32  core register-file write data for the current cycle.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_valid  out  1  rd_data holds a valid trace entry.
- rd_data  out  77  trace entry {z_MD, z_ALU_out, z_RF_WD}; z_MD occupies the MSBs.
- st  out  2  capture state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- triggered  out  1  high from the trigger edge until the next arm or reset.

Behaviour:
- Reset (asynchronous, any state, including mid-capture or mid-readout):
  - st=IDLE; wr_ptr=0; fill=0; post_cnt=0; rd_cnt=0; triggered=0.
  - rd_valid=0; rd_data=0.
  - Array contents are don't-care after reset.
- Trigger condition: hit = ((z_MD & trig_mask) == trig_match). A mask of all zeros gives hit=1 on every cycle.
- IDLE:
  - No writes.
  - arm moves the block to ARMED; on that edge wr_ptr=0, fill=0, triggered=0.
- ARMED (first sample is taken on the cycle after arm):
  - Every cycle: write {z_MD, z_ALU_out, z_RF_WD} at wr_ptr; wr_ptr=wr_ptr+1 with mod-DEPTH wrap; fill saturates at DEPTH.
  - If hit is true in the same cycle, that cycle's sample is still written; triggered=1 and post_cnt=POST.
  - On hit, go to POST if POST>0, otherwise go to DONE.
  - arm is ignored.
- POST:
  - Every cycle: write a sample as in ARMED and decrement post_cnt.
  - The write made while post_cnt=1 is the last one; go to DONE on that edge.
  - hit and arm are ignored.
- Entry into DONE:
  - rd_cnt = fill as of the final write (saturated value).
  - rd_ptr = wr_ptr - rd_cnt (mod DEPTH), which points at the oldest entry.
  - If the pre-trigger history overflowed, the oldest entries are overwritten and lost; the window retained is always the last min(samples, DEPTH) samples.
- DONE / readout:
  - rd_valid = (st==DONE) && (rd_cnt!=0).
  - rd_data = array[rd_ptr]; it is a combinational read and is stable while rd_valid is high and rd_ready is low.
  - On rd_valid && rd_ready: rd_ptr++ with wrap; rd_cnt--.
  - When the last entry is accepted, the block returns to IDLE on that edge; rd_valid is low in the next cycle.
  - rd_data shows array[rd_ptr] whenever st==DONE; it is 0 in every other state.
- arm while in DONE aborts the readout:
  - Go to ARMED with the same initialisation as from IDLE.
  - An rd_ready handshake in the same cycle is discarded; arm wins.
- Latency:
  - The trigger sample is written on the same edge the hit is seen.
  - DONE is entered POST cycles after the trigger edge.
  - The first rd_valid appears in the cycle after DONE is entered.
- Total entries read out = min(pre-trigger samples + 1 + POST, DEPTH).
- No backpressure is applied to the core. The core is never stalled, and samples are taken unconditionally in ARMED and POST.

Test Plan:
- Reset, then hold all inputs low for 5 cycles -> st=0, rd_valid=0, rd_data=0, triggered=0; assert reset mid-POST -> st=0 and triggered=0 immediately, before the next clock edge.
- DEPTH=16, POST=8, mask=0x1FFF, match=0x0A1: arm, 3 non-matching cycles, matching cycle with z_ALU_out=0x100, 8 more cycles with rd_ready=1 -> exactly 12 entries read in capture order, the 4th has ALU field 0x100, then st=0.
- Same setup but 40 pre-trigger cycles -> fill saturates; exactly 16 entries read; the first is the 7th-from-last pre-trigger sample; the trigger entry is 8th.
- mask=0 with POST=0: arm -> the trigger fires on the first ARMED cycle; DONE on that edge; a single entry is read.
- Readout with rd_ready toggled 1,0,0,1,… -> rd_data holds steady while ready is low; no entry skipped or duplicated; 16 entries then IDLE.
- arm asserted during DONE with 5 entries left and rd_ready=1 -> st=1 next cycle, rd_valid=0, triggered=0; the new capture behaves as in scenario 2.
